// File: rtl/gpu_isa_pkg.sv
// ----------------------------------------------------------------------------
// gpu_isa_pkg
// Shared ISA definitions for the compute unit front end.
// Contents:
//   - opcode values of the legal instructions
//   - instruction field bit positions
//   - fetch state encoding
// ----------------------------------------------------------------------------
package gpu_isa_pkg;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_LD   = 4'b0001;
    localparam logic [3:0] OP_ST   = 4'b0010;
    localparam logic [3:0] OP_PUSH = 4'b0100;
    localparam logic [3:0] OP_PULL = 4'b0101;
    localparam logic [3:0] OP_LDG  = 4'b1000;

    localparam int OP_MSB      = 15;
    localparam int OP_LSB      = 12;
    localparam int RA_MSB      = 11;
    localparam int RA_LSB      = 8;
    localparam int RB_MSB      = 7;
    localparam int RB_LSB      = 4;
    localparam int PUSH_PE_MSB = 7;
    localparam int PUSH_PE_LSB = 5;
    localparam int PUSH_SA_MSB = 4;
    localparam int PUSH_SA_LSB = 3;
    localparam int PULL_SA_MSB = 3;
    localparam int PULL_SA_LSB = 2;
    localparam int IMM4_MSB    = 3;
    localparam int IMM4_LSB    = 0;
    localparam int IMM8_MSB    = 7;
    localparam int IMM8_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_decode.sv
// ----------------------------------------------------------------------------
// instr_decode
// Combinational decoder from a 16-bit instruction word to issue-stage fields.
// Fields an opcode does not use are driven to zero, so an unused or illegal
// word never leaks stray bits into the output slot.
// Ports:
//   instr   in   instruction word
//   op      out  opcode (zero for HALT and illegal words)
//   reg_a   out  destination / source register
//   reg_b   out  address or PE register
//   imm     out  immediate
//   sa_id   out  systolic array id for PUSH/PULL
//   halt    out  word is HALT
//   illegal out  word carries an undefined opcode
// ----------------------------------------------------------------------------
module instr_decode
    import gpu_isa_pkg::*;
(
    input  logic [15:0] instr,
    output logic [3:0]  op,
    output logic [3:0]  reg_a,
    output logic [3:0]  reg_b,
    output logic [7:0]  imm,
    output logic [1:0]  sa_id,
    output logic        halt,
    output logic        illegal
);

    logic [3:0] opc;
    assign opc = instr[OP_MSB:OP_LSB];

    always_comb begin
        op      = '0;
        reg_a   = '0;
        reg_b   = '0;
        imm     = '0;
        sa_id   = '0;
        halt    = 1'b0;
        illegal = 1'b0;
        case (opc)
            OP_HALT: halt = 1'b1;
            OP_LD, OP_ST: begin
                op    = opc;
                reg_a = instr[RA_MSB:RA_LSB];
                reg_b = instr[RB_MSB:RB_LSB];
                imm   = {4'b0, instr[IMM4_MSB:IMM4_LSB]};
            end
            OP_PUSH: begin
                op    = opc;
                reg_a = instr[RA_MSB:RA_LSB];
                reg_b = {1'b0, instr[PUSH_PE_MSB:PUSH_PE_LSB]};
                sa_id = instr[PUSH_SA_MSB:PUSH_SA_LSB];
            end
            OP_PULL: begin
                op    = opc;
                reg_a = instr[RA_MSB:RA_LSB];
                reg_b = instr[RB_MSB:RB_LSB];
                sa_id = instr[PULL_SA_MSB:PULL_SA_LSB];
            end
            OP_LDG: begin
                op    = opc;
                reg_a = instr[RA_MSB:RA_LSB];
                imm   = instr[IMM8_MSB:IMM8_LSB];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: owns the PC, reads the instruction ROM, decodes each word and
// presents it through one registered valid/ready slot. Stops on HALT or on an
// illegal opcode (the latter also sets the sticky error flag).
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | out of reset, waiting for start
//   ST_FETCH  | fetching one word per cycle whenever the slot can load
//   ST_HALTED | stopped on HALT/illegal; pending slot drains, start resumes
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, start_pc     begin fetching at start_pc (bit 0 ignored)
//   pc_out, instr_in    ROM address out, ROM word back (combinational)
//   out_valid/out_ready output slot handshake
//   op, reg_a, reg_b, imm, sa_id, inst_pc   slot contents
//   busy, halted, error status
// ----------------------------------------------------------------------------
module instruction_fetch
    import gpu_isa_pkg::*;
#(
    parameter int PC_WIDTH   = 8,
    parameter int INST_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PC_WIDTH-1:0]   start_pc,
    output logic [PC_WIDTH-1:0]   pc_out,
    input  logic [INST_WIDTH-1:0] instr_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            op,
    output logic [3:0]            reg_a,
    output logic [3:0]            reg_b,
    output logic [7:0]            imm,
    output logic [1:0]            sa_id,
    output logic [PC_WIDTH-1:0]   inst_pc,
    output logic                  busy,
    output logic                  halted,
    output logic                  error
);

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] start_pc_even;
    logic                can_load;

    logic [3:0] dec_op;
    logic [3:0] dec_reg_a;
    logic [3:0] dec_reg_b;
    logic [7:0] dec_imm;
    logic [1:0] dec_sa_id;
    logic       dec_halt;
    logic       dec_illegal;

    instr_decode u_decode (
        .instr   (instr_in),
        .op      (dec_op),
        .reg_a   (dec_reg_a),
        .reg_b   (dec_reg_b),
        .imm     (dec_imm),
        .sa_id   (dec_sa_id),
        .halt    (dec_halt),
        .illegal (dec_illegal)
    );

    assign start_pc_even = start_pc & ~PC_WIDTH'(1);
    assign can_load      = !out_valid || out_ready;
    assign pc_out        = pc;
    assign busy          = (state == ST_FETCH);
    assign halted        = (state == ST_HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            out_valid <= 1'b0;
            op        <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            imm       <= '0;
            sa_id     <= '0;
            inst_pc   <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc    <= start_pc_even;
                        error <= 1'b0;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (can_load) begin
                        if (dec_halt || dec_illegal) begin
                            // Stop word is never presented; pc stays on it.
                            out_valid <= 1'b0;
                            state     <= ST_HALTED;
                            if (dec_illegal)
                                error <= 1'b1;
                        end else begin
                            op        <= dec_op;
                            reg_a     <= dec_reg_a;
                            reg_b     <= dec_reg_b;
                            imm       <= dec_imm;
                            sa_id     <= dec_sa_id;
                            inst_pc   <= pc;
                            out_valid <= 1'b1;
                            pc        <= pc + PC_WIDTH'(2);
                        end
                    end
                end
                ST_HALTED: begin
                    // A pending slot must drain before a restart is accepted.
                    if (out_valid) begin
                        if (out_ready)
                            out_valid <= 1'b0;
                    end else if (start) begin
                        pc    <= start_pc_even;
                        error <= 1'b0;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the compute unit: owns the program counter, drives the byte address into the instruction ROM, and captures the returned 16-bit word. Each instruction is decoded into fields and presented to the issue stage through a single registered valid/ready output slot. Fetch stops on HALT or on an illegal opcode.

## Interface
- PC_WIDTH, 8, byte-address width; ROM word index is pc[7:1]
- INST_WIDTH, 16, instruction width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous and active-low
- start  in  1  one-cycle pulse; begins fetch at start_pc; honoured only in IDLE or HALTED
- start_pc  in  PC_WIDTH  first fetch address; bit 0 forced to 0
- pc_out  out  PC_WIDTH  address to ROM read_addr; always even
- instr_in  in  INST_WIDTH  ROM data, combinational from pc_out
- out_valid  out  1  decoded slot holds an instruction
- out_ready  in  1  issue stage accepts the slot this cycle
- op  out  4  instr[15:12]
- reg_a  out  4  instr[11:8]: destination for LD/LDG/PULL, source for ST/PUSH
- reg_b  out  4  address register for LD/ST (instr[7:4]); PE register for PULL (instr[7:4]); PE register for PUSH ({1'b0, instr[7:5]}); 0 for LDG
- imm  out  8  LDG: instr[7:0]; LD/ST: {4'b0, instr[3:0]}; others 0
- sa_id  out  2  PUSH: instr[4:3]; PULL: instr[3:2]; others 0
- inst_pc  out  PC_WIDTH  address the slot was fetched from
- busy  out  1  state is FETCH
- halted  out  1  state is HALTED
- error  out  1  sticky; set by an illegal opcode, cleared by start or reset

## Operation
- Legal opcodes: 0000 HALT, 0001 LD, 0010 ST, 0100 PUSH, 0101 PULL, 1000 LDG. All other opcodes are illegal.
- States: IDLE, FETCH, HALTED.
- IDLE: on start, pc <= {start_pc[7:1], 1'b0} and go to FETCH.
- FETCH: the slot can load when `!out_valid || out_ready`. When it can load:
  - Legal non-HALT: latch the decoded fields and inst_pc <= pc, set out_valid=1, pc <= pc+2.
  - HALT: not presented; out_valid <= 0 if the current slot is being accepted; go to HALTED; pc is unchanged.
  - Illegal: same as HALT, and error <= 1.
- FETCH with a full slot and out_ready=0: hold pc and the slot.
- HALTED: a slot already held stays valid until accepted. On start, go to FETCH at the new start_pc and clear error. A start while a slot is still pending is ignored.
- A start pulse while in FETCH is ignored.
- PC wraps from 0xFE to 0x00 with no flag.
- Fields of invalid slots are don't-care but must not produce X; the decoder zero-fills them.

## Timing
- Reset values: pc_out=0, out_valid=0, op=0, reg_a=0, reg_b=0, imm=0, sa_id=0, inst_pc=0, busy=0, halted=0, error=0, state IDLE.
- start sampled at edge N: at N+1 pc_out=start_pc and busy=1; the first out_valid is at N+2.
- Throughput with out_ready held high: one instruction per cycle.
- Stall: while out_valid && !out_ready, every output and pc_out is stable.
- Simultaneous accept and load in the same cycle: the slot is replaced with no bubble.
- HALT at address A: halted=1 one cycle after pc_out=A; pc_out stays at A.
- rst_n low at any edge: the next cycle shows reset values, regardless of state or pending slot.

## Structure
- `gpu_isa_pkg` holds:
  - opcode localparams (OP_HALT, OP_LD, OP_ST, OP_PUSH, OP_PULL, OP_LDG)
  - field bit positions
  - the fetch state enum
- One combinational sub-module, `instr_decode`: maps instr to op, reg_a, reg_b, imm, sa_id and an illegal/halt flag.
- The fetch FSM, pc register and output slot live in `instruction_fetch`.

## Test plan
- ROM[0..2] = 0x1A53 (LD), 0x8107 (LDG), 0x0000; start_pc=0x00, out_ready=1 -> slot 1: op=1, reg_a=A, reg_b=5, imm=0x03, inst_pc=0x00; slot 2: op=8, reg_a=1, imm=0x07, inst_pc=0x02; then halted=1 with pc_out=0x04 and no third valid.
- Same program with out_ready low for 3 cycles after the first valid -> slot holds 0x1A53 decode and pc_out is stable; both instructions still arrive exactly once, in order.
- PUSH 0x4378 -> reg_a=3, reg_b=3, sa_id=3; PULL 0x52AC -> reg_a=2, reg_b=A, sa_id=3.
- Word 0x3000 at 0x06 -> error=1, halted=1, nothing emitted for it; then start with start_pc=0x10 -> error=0 and fetch resumes at 0x10.
- start_pc=0xFE holding an LD, ROM[0] = LD -> inst_pc sequence 0xFE then 0x00 (wrap).
- rst_n low mid-stream while a slot is stalled -> next cycle shows all reset values and IDLE; a start during FETCH is ignored.
